reg_loader: RTL

REG_LOADER -- requirements
Module: reg_loader

---
 rtl/reg_loader.sv | 112 +++++++++++
 1 files changed

// File: rtl/reg_loader.sv
// Burst register loader: latches a base address and count, then writes one upstream beat per register.
// Optional REG_LOADER_PROTECT_R0_EN suppresses the write strobe for register 0.
module reg_loader (
    input  logic       CLK,
    input  logic       RESET,
    input  logic       START,
    input  logic [2:0] BASEADDR,
    input  logic [2:0] COUNT,
    input  logic [7:0] DATAIN,
    input  logic       DATAVALID,
    output logic       DATAREADY,
    output logic [7:0] WRITEDATA,
    output logic [2:0] WRITEREG,
    output logic       WRITEENABLE,
    output logic       BUSY,
    output logic       DONE
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCEPT = 2'd1,
        WRITE  = 2'd2,
        FINISH = 2'd3
    } state_t;

    state_t     r_state;
    state_t     w_next;
    logic [2:0] r_addr;
    logic [2:0] r_cnt;
    logic [2:0] w_addr_nxt;
    logic [2:0] w_cnt_nxt;

    logic       w_ready;
    logic [7:0] w_wdata;
    logic [2:0] w_wreg;
    logic       w_we;
    logic       w_busy;
    logic       w_done;

    always_ff @(posedge CLK) begin
        if (!RESET) begin
            r_state     <= IDLE;
            r_addr      <= 3'd0;
            r_cnt       <= 3'd0;
            DATAREADY   <= 1'b0;
            WRITEDATA   <= 8'd0;
            WRITEREG    <= 3'd0;
            WRITEENABLE <= 1'b0;
            BUSY        <= 1'b0;
            DONE        <= 1'b0;
        end else begin
            r_state     <= w_next;
            r_addr      <= w_addr_nxt;
            r_cnt       <= w_cnt_nxt;
            DATAREADY   <= w_ready;
            WRITEDATA   <= w_wdata;
            WRITEREG    <= w_wreg;
            WRITEENABLE <= w_we;
            BUSY        <= w_busy;
            DONE        <= w_done;
        end
    end

    always_comb begin
        w_next     = r_state;
        w_addr_nxt = r_addr;
        w_cnt_nxt  = r_cnt;
        unique case (r_state)
            IDLE: begin
                if (START) begin
                    w_next     = ACCEPT;
                    w_addr_nxt = BASEADDR;
                    w_cnt_nxt  = COUNT;
                end
            end
            ACCEPT: begin
                if (DATAVALID)
                    w_next = WRITE;
            end
            WRITE: begin
                w_addr_nxt = r_addr + 3'd1;
                if (r_cnt == 3'd0) begin
                    w_next = FINISH;
                end else begin
                    w_next    = ACCEPT;
                    w_cnt_nxt = r_cnt - 3'd1;
                end
            end
            FINISH: w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    // Outputs are decoded from the next state so they line up with the state they describe.
    always_comb begin
        w_ready = (w_next == ACCEPT);
        w_busy  = (w_next != IDLE);
        w_done  = (w_next == FINISH);
        w_wdata = WRITEDATA;
        w_wreg  = WRITEREG;
`ifdef REG_LOADER_PROTECT_R0_EN
        w_we    = (w_next == WRITE) && (r_addr != 3'd0);
`else
        w_we    = (w_next == WRITE);
`endif
        if (r_state == ACCEPT && DATAVALID) begin
            w_wdata = DATAIN;
            w_wreg  = r_addr;
        end
    end

endmodule
